// File: rtl/rd_bank_arbiter.sv
// rd_bank_arbiter
// Per-bank read arbiter placed in front of the banked memory read ports.
// Every cycle at most one read is accepted per bank. Same-bank conflicts are
// resolved by a per-bank round-robin pointer, and banks owned by the write
// side are held off. Losing agents see req_ready low and must keep their
// request stable. Accepted reads are issued one cycle later on m_rden/m_bank.
//
// Ports
//   aclk, areset   clock (rising edge), asynchronous active-high reset
//   req_valid      per-agent read request
//   req_bank       per-agent bank index, agent i at [i*SELECT_WIDTH +: SELECT_WIDTH]
//   req_ready      per-agent grant (combinational)
//   bank_wr_busy   per-bank write ownership; a busy bank grants nobody
//   m_rden         registered read enable toward the memory
//   m_bank         registered bank index, zero for agents not granted
//   collision      registered: some valid request was stalled last cycle
//   stall_cnt      saturating count of cycles with at least one stall
//   stall_clr      synchronous clear of stall_cnt (wins over increment)
module rd_bank_arbiter #(
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = 4,
  parameter int NB_BANK      = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [NB_RDAGENT-1:0]              req_valid,
  input  logic [NB_RDAGENT*SELECT_WIDTH-1:0] req_bank,
  output logic [NB_RDAGENT-1:0]              req_ready,
  input  logic [NB_BANK-1:0]                 bank_wr_busy,
  output logic [NB_RDAGENT-1:0]              m_rden,
  output logic [NB_RDAGENT*SELECT_WIDTH-1:0] m_bank,
  output logic                               collision,
  output logic [CNT_WIDTH-1:0]               stall_cnt,
  input  logic                               stall_clr
);

  localparam int PW = (NB_RDAGENT > 1) ? $clog2(NB_RDAGENT) : 1;

  logic [NB_RDAGENT-1:0][SELECT_WIDTH-1:0] bank_sel;
  assign bank_sel = req_bank;

  logic [NB_BANK-1:0][PW-1:0]                ptr_q, ptr_d;
  logic [NB_RDAGENT-1:0]                     m_rden_q, m_rden_d;
  logic [NB_RDAGENT-1:0][SELECT_WIDTH-1:0]   m_bank_q, m_bank_d;
  logic                                      collision_q, collision_d;
  logic [CNT_WIDTH-1:0]                      stall_cnt_q, stall_cnt_d;
  logic [NB_RDAGENT-1:0]                     grant;
  logic                                      stall;

  // Position of agent j in the round-robin order that starts at agent p.
  function automatic int rr_dist(input int j, input int p);
    return (j >= p) ? (j - p) : (j + NB_RDAGENT - p);
  endfunction

  // Grant: valid, bank in range and not write-owned, and no same-bank valid
  // agent sits ahead in that bank's round-robin order.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NB_RDAGENT; i++) begin
      int  b;
      int  p;
      logic blocked;
      b       = int'(bank_sel[i]);
      p       = 0;
      blocked = 1'b0;
      if (req_valid[i] && (b < NB_BANK)) begin
        p = int'(ptr_q[b]);
        if (!bank_wr_busy[b]) begin
          for (int j = 0; j < NB_RDAGENT; j++) begin
            if ((j != i) && req_valid[j] && (bank_sel[j] == bank_sel[i]) &&
                (rr_dist(j, p) < rr_dist(i, p)))
              blocked = 1'b1;
          end
          grant[i] = !blocked;
        end
      end
    end
  end

  assign req_ready = grant;
  assign stall     = |(req_valid & ~grant);

  // Pointer moves past the winner only when the bank was actually contended
  // and free; a lone requester leaves the order untouched.
  always_comb begin
    ptr_d = ptr_q;
    for (int b = 0; b < NB_BANK; b++) begin
      int cnt;
      int winner;
      cnt    = 0;
      winner = 0;
      for (int i = 0; i < NB_RDAGENT; i++) begin
        if (req_valid[i] && (int'(bank_sel[i]) == b)) begin
          cnt = cnt + 1;
          if (grant[i]) winner = i;
        end
      end
      if ((cnt >= 2) && !bank_wr_busy[b])
        ptr_d[b] = PW'((winner + 1) % NB_RDAGENT);
    end
  end

  always_comb begin
    m_rden_d    = req_valid & grant;
    m_bank_d    = '0;
    for (int i = 0; i < NB_RDAGENT; i++)
      if (req_valid[i] && grant[i]) m_bank_d[i] = bank_sel[i];
    collision_d = stall;
    stall_cnt_d = stall_cnt_q;
    if (stall_clr)
      stall_cnt_d = '0;
    else if (stall && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr_q       <= '0;
      m_rden_q    <= '0;
      m_bank_q    <= '0;
      collision_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      m_rden_q    <= m_rden_d;
      m_bank_q    <= m_bank_d;
      collision_q <= collision_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign m_rden    = m_rden_q;
  assign m_bank    = m_bank_q;
  assign collision = collision_q;
  assign stall_cnt = stall_cnt_q;

`ifndef SYNTHESIS
  for (genvar i = 0; i < NB_RDAGENT; i++) begin : g_chk_agent
    a_bank_range: assert property (@(posedge aclk) disable iff (areset)
      req_valid[i] |-> (int'(bank_sel[i]) < NB_BANK));
    a_hold: assert property (@(posedge aclk) disable iff (areset)
      (req_valid[i] && !grant[i]) |=> (req_valid[i] && $stable(bank_sel[i])));
    for (genvar j = i + 1; j < NB_RDAGENT; j++) begin : g_chk_pair
      a_one_per_bank: assert property (@(posedge aclk) disable iff (areset)
        !(m_rden_q[i] && m_rden_q[j] && (m_bank_q[i] == m_bank_q[j])));
    end
  end
`endif

endmodule

// File: tb/tb_rd_bank_arbiter.sv
module tb_rd_bank_arbiter;
  logic aclk = 1'b0;
  logic areset;
  logic stall_clr;
  logic [15:0] busy;

  // Instances A (2 agents, 16-bit counter) and C (2 agents, 2-bit counter)
  // share request inputs; instance B has 4 agents.
  logic [1:0]  vld;
  logic [7:0]  bnk;
  logic [1:0]  rdy_a, rden_a, rdy_c, rden_c;
  logic [7:0]  mbank_a, mbank_c;
  logic        coll_a, coll_c;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_c;

  logic [3:0]  vld_b, rdy_b, rden_b;
  logic [15:0] bnk_b, mbank_b, cnt_b;
  logic        coll_b;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  rd_bank_arbiter #(.NB_RDAGENT(2), .SELECT_WIDTH(4), .NB_BANK(16), .CNT_WIDTH(16)) u_a (
    .aclk(aclk), .areset(areset), .req_valid(vld), .req_bank(bnk), .req_ready(rdy_a),
    .bank_wr_busy(busy), .m_rden(rden_a), .m_bank(mbank_a), .collision(coll_a),
    .stall_cnt(cnt_a), .stall_clr(stall_clr));

  rd_bank_arbiter #(.NB_RDAGENT(4), .SELECT_WIDTH(4), .NB_BANK(16), .CNT_WIDTH(16)) u_b (
    .aclk(aclk), .areset(areset), .req_valid(vld_b), .req_bank(bnk_b), .req_ready(rdy_b),
    .bank_wr_busy(busy), .m_rden(rden_b), .m_bank(mbank_b), .collision(coll_b),
    .stall_cnt(cnt_b), .stall_clr(stall_clr));

  rd_bank_arbiter #(.NB_RDAGENT(2), .SELECT_WIDTH(4), .NB_BANK(16), .CNT_WIDTH(2)) u_c (
    .aclk(aclk), .areset(areset), .req_valid(vld), .req_bank(bnk), .req_ready(rdy_c),
    .bank_wr_busy(busy), .m_rden(rden_c), .m_bank(mbank_c), .collision(coll_c),
    .stall_cnt(cnt_c), .stall_clr(stall_clr));

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic do_reset();
    areset = 1'b1; vld = '0; bnk = '0; vld_b = '0; bnk_b = '0; busy = '0; stall_clr = 1'b0;
    step();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; vld = '0; bnk = '0; vld_b = '0; bnk_b = '0; busy = '0; stall_clr = 1'b0;
    #2;
    checks++; if (rden_a !== 2'b00) begin errors++; $display("FAIL reset_rden got %b exp 00", rden_a); end
    checks++; if (mbank_a !== 8'h00) begin errors++; $display("FAIL reset_mbank got %h exp 00", mbank_a); end
    checks++; if (coll_a !== 1'b0) begin errors++; $display("FAIL reset_coll got %b exp 0", coll_a); end
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt_a); end
    checks++; if (rdy_a !== 2'b00) begin errors++; $display("FAIL reset_rdy got %b exp 00", rdy_a); end
    step();
    areset = 1'b0;
  endtask

  task automatic test_single();
    vld = 2'b01; bnk = 8'h03; #1;
    checks++; if (rdy_a !== 2'b01) begin errors++; $display("FAIL single_rdy got %b exp 01", rdy_a); end
    step();
    checks++; if (rden_a !== 2'b01) begin errors++; $display("FAIL single_rden got %b exp 01", rden_a); end
    checks++; if (mbank_a !== 8'h03) begin errors++; $display("FAIL single_mbank got %h exp 03", mbank_a); end
    checks++; if (coll_a !== 1'b0) begin errors++; $display("FAIL single_coll got %b exp 0", coll_a); end
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL single_cnt got %0d exp 0", cnt_a); end
    // ptr[3] must still be 0: a contended bank 3 goes to agent 0 first
    vld = 2'b11; bnk = 8'h33; #1;
    checks++; if (rdy_a !== 2'b01) begin errors++; $display("FAIL single_ptr_hold got %b exp 01", rdy_a); end
    step();
    checks++; if (coll_a !== 1'b1) begin errors++; $display("FAIL single_coll2 got %b exp 1", coll_a); end
    checks++; if (rdy_a !== 2'b10) begin errors++; $display("FAIL single_rr got %b exp 10", rdy_a); end
    step();
    checks++; if (mbank_a !== 8'h30) begin errors++; $display("FAIL single_mbank2 got %h exp 30", mbank_a); end
    do_reset();
  endtask

  task automatic test_contend_2();
    vld = 2'b11; bnk = 8'h55; #1;
    checks++; if (rdy_a !== 2'b01) begin errors++; $display("FAIL c2_rdy0 got %b exp 01", rdy_a); end
    step();
    checks++; if (rden_a !== 2'b01) begin errors++; $display("FAIL c2_rden0 got %b exp 01", rden_a); end
    checks++; if (mbank_a !== 8'h05) begin errors++; $display("FAIL c2_mbank0 got %h exp 05", mbank_a); end
    checks++; if (coll_a !== 1'b1) begin errors++; $display("FAIL c2_coll1 got %b exp 1", coll_a); end
    checks++; if (cnt_a !== 16'd1) begin errors++; $display("FAIL c2_cnt1 got %0d exp 1", cnt_a); end
    checks++; if (rdy_a !== 2'b10) begin errors++; $display("FAIL c2_rdy1 got %b exp 10", rdy_a); end
    step();
    checks++; if (rden_a !== 2'b10) begin errors++; $display("FAIL c2_rden1 got %b exp 10", rden_a); end
    checks++; if (mbank_a !== 8'h50) begin errors++; $display("FAIL c2_mbank1 got %h exp 50", mbank_a); end
    checks++; if (coll_a !== 1'b1) begin errors++; $display("FAIL c2_coll2 got %b exp 1", coll_a); end
    checks++; if (cnt_a !== 16'd2) begin errors++; $display("FAIL c2_cnt2 got %0d exp 2", cnt_a); end
    checks++; if (rdy_a !== 2'b01) begin errors++; $display("FAIL c2_rdy2 got %b exp 01", rdy_a); end
    do_reset();
  endtask

  task automatic test_contend_4();
    vld_b = 4'b1111; bnk_b = 16'h2222; #1;
    checks++; if (rdy_b !== 4'b0001) begin errors++; $display("FAIL c4_rdy0 got %b exp 0001", rdy_b); end
    step();
    checks++; if (rden_b !== 4'b0001) begin errors++; $display("FAIL c4_rden0 got %b exp 0001", rden_b); end
    vld_b = 4'b1110; #1;
    checks++; if (rdy_b !== 4'b0010) begin errors++; $display("FAIL c4_rdy1 got %b exp 0010", rdy_b); end
    step();
    checks++; if (mbank_b !== 16'h0020) begin errors++; $display("FAIL c4_mbank1 got %h exp 0020", mbank_b); end
    vld_b = 4'b1100; #1;
    checks++; if (rdy_b !== 4'b0100) begin errors++; $display("FAIL c4_rdy2 got %b exp 0100", rdy_b); end
    step();
    vld_b = 4'b1000; #1;
    checks++; if (rdy_b !== 4'b1000) begin errors++; $display("FAIL c4_rdy3 got %b exp 1000", rdy_b); end
    step();
    checks++; if (rden_b !== 4'b1000) begin errors++; $display("FAIL c4_rden3 got %b exp 1000", rden_b); end
    checks++; if (mbank_b !== 16'h2000) begin errors++; $display("FAIL c4_mbank3 got %h exp 2000", mbank_b); end
    checks++; if (cnt_b !== 16'd3) begin errors++; $display("FAIL c4_cnt got %0d exp 3", cnt_b); end
    checks++; if (coll_b !== 1'b0) begin errors++; $display("FAIL c4_coll got %b exp 0", coll_b); end
    do_reset();
  endtask

  task automatic test_busy();
    busy = 16'h0080; vld = 2'b10; bnk = 8'h70;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (rdy_a !== 2'b00) begin errors++; $display("FAIL busy_rdy%0d got %b exp 00", k, rdy_a); end
      step();
    end
    checks++; if (cnt_a !== 16'd3) begin errors++; $display("FAIL busy_cnt got %0d exp 3", cnt_a); end
    checks++; if (rden_a !== 2'b00) begin errors++; $display("FAIL busy_rden got %b exp 00", rden_a); end
    busy = 16'h0000; #1;
    checks++; if (rdy_a !== 2'b10) begin errors++; $display("FAIL busy_release_rdy got %b exp 10", rdy_a); end
    step();
    checks++; if (rden_a !== 2'b10) begin errors++; $display("FAIL busy_release_rden got %b exp 10", rden_a); end
    checks++; if (mbank_a !== 8'h70) begin errors++; $display("FAIL busy_release_mbank got %h exp 70", mbank_a); end
    vld = 2'b11; bnk = 8'h77; #1;
    checks++; if (rdy_a !== 2'b01) begin errors++; $display("FAIL busy_ptr_hold got %b exp 01", rdy_a); end
    do_reset();
  endtask

  task automatic test_distinct();
    vld = 2'b11; bnk = 8'h21; #1;
    checks++; if (rdy_a !== 2'b11) begin errors++; $display("FAIL dist_rdy got %b exp 11", rdy_a); end
    step();
    checks++; if (rden_a !== 2'b11) begin errors++; $display("FAIL dist_rden got %b exp 11", rden_a); end
    checks++; if (mbank_a !== 8'h21) begin errors++; $display("FAIL dist_mbank got %h exp 21", mbank_a); end
    checks++; if (coll_a !== 1'b0) begin errors++; $display("FAIL dist_coll got %b exp 0", coll_a); end
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL dist_cnt got %0d exp 0", cnt_a); end
    do_reset();
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [4];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
    vld = 2'b11; bnk = 8'h55;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (cnt_c !== exp_cnt[k]) begin errors++; $display("FAIL sat_cnt%0d got %0d exp %0d", k, cnt_c, exp_cnt[k]); end
    end
    stall_clr = 1'b1;
    step();
    checks++; if (cnt_c !== 2'd0) begin errors++; $display("FAIL sat_clr got %0d exp 0", cnt_c); end
    checks++; if (coll_c !== 1'b1) begin errors++; $display("FAIL sat_coll got %b exp 1", coll_c); end
    stall_clr = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid();
    vld = 2'b11; bnk = 8'h55;
    step();
    checks++; if (rden_a !== 2'b01) begin errors++; $display("FAIL mid_pre_rden got %b exp 01", rden_a); end
    #2 areset = 1'b1; #1;
    checks++; if (rden_a !== 2'b00) begin errors++; $display("FAIL mid_rden got %b exp 00", rden_a); end
    checks++; if (mbank_a !== 8'h00) begin errors++; $display("FAIL mid_mbank got %h exp 00", mbank_a); end
    checks++; if (coll_a !== 1'b0) begin errors++; $display("FAIL mid_coll got %b exp 0", coll_a); end
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL mid_cnt got %0d exp 0", cnt_a); end
    step();
    areset = 1'b0; #1;
    checks++; if (rdy_a !== 2'b01) begin errors++; $display("FAIL mid_rearb got %b exp 01", rdy_a); end
    step();
    checks++; if (rden_a !== 2'b01) begin errors++; $display("FAIL mid_rden_after got %b exp 01", rden_a); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contend_2();
    test_contend_4();
    test_busy();
    test_distinct();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
